// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencing FSM for the 8-bit CPU
module control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR_out,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic [2:0] ALU_Sel,
  output logic       write
);

  localparam logic [4:0] S_F0  = 5'd0;
  localparam logic [4:0] S_F1  = 5'd1;
  localparam logic [4:0] S_F2  = 5'd2;
  localparam logic [4:0] S_DEC = 5'd3;
  localparam logic [4:0] S_I0  = 5'd4;
  localparam logic [4:0] S_I1  = 5'd5;
  localparam logic [4:0] S_I2  = 5'd6;
  localparam logic [4:0] S_D0  = 5'd7;
  localparam logic [4:0] S_D1  = 5'd8;
  localparam logic [4:0] S_D2  = 5'd9;
  localparam logic [4:0] S_D3  = 5'd10;
  localparam logic [4:0] S_D4  = 5'd11;
  localparam logic [4:0] S_S3  = 5'd12;
  localparam logic [4:0] S_X0  = 5'd13;
  localparam logic [4:0] S_B0  = 5'd14;
  localparam logic [4:0] S_B1  = 5'd15;
  localparam logic [4:0] S_B2  = 5'd16;
  localparam logic [4:0] S_N0  = 5'd17;

  logic [4:0] state;
  logic [4:0] state_next;

  logic is_ld_imm, is_ld_dir, is_st, is_alu, is_br, dest_b, br_taken;
  logic [2:0] alu_op;

  logic       ir_load_c, mar_load_c, pc_load_c, pc_inc_c;
  logic       a_load_c, b_load_c, ccr_load_c, write_c;
  logic [1:0] bus1_c, bus2_c;
  logic [2:0] alu_c;

  // Opcode classification, destination register, ALU function and branch condition
  always_comb begin
    is_ld_imm = (IR_out == 8'h86) || (IR_out == 8'h88);
    is_ld_dir = (IR_out == 8'h87) || (IR_out == 8'h89);
    is_st     = (IR_out == 8'h96) || (IR_out == 8'h97);
    is_alu    = (IR_out >= 8'h42) && (IR_out <= 8'h49);
    is_br     = (IR_out >= 8'h20) && (IR_out <= 8'h28);
    dest_b    = (IR_out == 8'h88) || (IR_out == 8'h89) || (IR_out == 8'h97) ||
                (IR_out == 8'h47) || (IR_out == 8'h49);
    case (IR_out)
      8'h42:        alu_op = 3'b000;
      8'h43:        alu_op = 3'b010;
      8'h44:        alu_op = 3'b100;
      8'h45:        alu_op = 3'b101;
      8'h46, 8'h47: alu_op = 3'b001;
      8'h48, 8'h49: alu_op = 3'b011;
      default:      alu_op = 3'b000;
    endcase
    case (IR_out)
      8'h20:   br_taken = 1'b1;
      8'h21:   br_taken = CCR_Result[3];
      8'h22:   br_taken = ~CCR_Result[3];
      8'h23:   br_taken = CCR_Result[2];
      8'h24:   br_taken = ~CCR_Result[2];
      8'h25:   br_taken = CCR_Result[1];
      8'h26:   br_taken = ~CCR_Result[1];
      8'h27:   br_taken = CCR_Result[0];
      8'h28:   br_taken = ~CCR_Result[0];
      default: br_taken = 1'b0;
    endcase
  end

  // State register; reset parks the machine in F0
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_F0;
    else        state <= state_next;
  end

  // Next-state sequencing; flags only matter when leaving DEC
  always_comb begin
    state_next = S_F0;
    case (state)
      S_F0:  state_next = S_F1;
      S_F1:  state_next = S_F2;
      S_F2:  state_next = S_DEC;
      S_DEC: begin
        if (is_ld_imm)              state_next = S_I0;
        else if (is_ld_dir || is_st) state_next = S_D0;
        else if (is_alu)            state_next = S_X0;
        else if (is_br)             state_next = br_taken ? S_B0 : S_N0;
        else                        state_next = S_F0;
      end
      S_I0:  state_next = S_I1;
      S_I1:  state_next = S_I2;
      S_D0:  state_next = S_D1;
      S_D1:  state_next = S_D2;
      S_D2:  state_next = is_st ? S_S3 : S_D3;
      S_D3:  state_next = S_D4;
      S_B0:  state_next = S_B1;
      S_B1:  state_next = S_B2;
      default: state_next = S_F0;
    endcase
  end

  // Moore output decode from state and the held opcode
  always_comb begin
    ir_load_c  = 1'b0;
    mar_load_c = 1'b0;
    pc_load_c  = 1'b0;
    pc_inc_c   = 1'b0;
    a_load_c   = 1'b0;
    b_load_c   = 1'b0;
    ccr_load_c = 1'b0;
    write_c    = 1'b0;
    bus1_c     = 2'b00;
    bus2_c     = 2'b00;
    alu_c      = 3'b000;
    case (state)
      S_F0, S_I0, S_D0, S_B0: begin
        bus1_c     = 2'b00;
        bus2_c     = 2'b01;
        mar_load_c = 1'b1;
      end
      S_F1, S_I1, S_D1, S_N0: pc_inc_c = 1'b1;
      S_F2: begin
        bus2_c    = 2'b10;
        ir_load_c = 1'b1;
      end
      S_I2, S_D4: begin
        bus2_c   = 2'b10;
        a_load_c = ~dest_b;
        b_load_c = dest_b;
      end
      S_D2: begin
        bus2_c     = 2'b10;
        mar_load_c = 1'b1;
      end
      S_S3: begin
        bus1_c  = dest_b ? 2'b10 : 2'b01;
        write_c = 1'b1;
      end
      S_X0: begin
        bus1_c     = dest_b ? 2'b10 : 2'b01;
        bus2_c     = 2'b00;
        alu_c      = alu_op;
        a_load_c   = ~dest_b;
        b_load_c   = dest_b;
        ccr_load_c = 1'b1;
      end
      S_B2: begin
        bus2_c    = 2'b10;
        pc_load_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every output directly so a pending write dies without waiting for a clock
  assign IR_Load  = Reset & ir_load_c;
  assign MAR_Load = Reset & mar_load_c;
  assign PC_Load  = Reset & pc_load_c;
  assign PC_Inc   = Reset & pc_inc_c;
  assign A_Load   = Reset & a_load_c;
  assign B_Load   = Reset & b_load_c;
  assign CCR_Load = Reset & ccr_load_c;
  assign write    = Reset & write_c;
  assign Bus1_Sel = Reset ? bus1_c : 2'b00;
  assign Bus2_Sel = Reset ? bus2_c : 2'b00;
  assign ALU_Sel  = Reset ? alu_c  : 3'b000;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] IR_out;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [2:0] ALU_Sel;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR_out(IR_out), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .ALU_Sel(ALU_Sel), .write(write)
  );

  always #5 Clk = ~Clk;

  typedef logic [14:0] ow_t;
  ow_t dut_w;
  assign dut_w = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                  Bus1_Sel, Bus2_Sel, ALU_Sel, write};

  int total = 0;
  int bad   = 0;

  function automatic ow_t mk(input bit irl, input bit marl, input bit pcl, input bit pci,
                             input bit al, input bit bl, input bit ccrl,
                             input logic [1:0] b1, input logic [1:0] b2,
                             input logic [2:0] alu, input bit wr);
    return {irl, marl, pcl, pci, al, bl, ccrl, b1, b2, alu, wr};
  endfunction

  // Reference: expected per-cycle output words for one whole instruction
  function automatic void model(input logic [7:0] op, input logic [3:0] ccr, output ow_t q[$]);
    ow_t mar_pc, inc, idle, mem_to;
    bit  to_b, taken, flag;
    int  idx;
    mar_pc = mk(0,1,0,0,0,0,0,2'b00,2'b01,3'b000,0);
    inc    = mk(0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0);
    idle   = '0;
    to_b   = (op == 8'h88 || op == 8'h89 || op == 8'h97 || op == 8'h47 || op == 8'h49);
    mem_to = mk(0,0,0,0,!to_b,to_b,0,2'b00,2'b10,3'b000,0);
    q = {};
    q.push_back(mar_pc);
    q.push_back(inc);
    q.push_back(mk(1,0,0,0,0,0,0,2'b00,2'b10,3'b000,0));
    q.push_back(idle);
    case (op)
      8'h86, 8'h88: begin q.push_back(mar_pc); q.push_back(inc); q.push_back(mem_to); end
      8'h87, 8'h89: begin
        q.push_back(mar_pc); q.push_back(inc);
        q.push_back(mk(0,1,0,0,0,0,0,2'b00,2'b10,3'b000,0));
        q.push_back(idle); q.push_back(mem_to);
      end
      8'h96, 8'h97: begin
        q.push_back(mar_pc); q.push_back(inc);
        q.push_back(mk(0,1,0,0,0,0,0,2'b00,2'b10,3'b000,0));
        q.push_back(mk(0,0,0,0,0,0,0,to_b ? 2'b10 : 2'b01,2'b00,3'b000,1));
      end
      8'h42: q.push_back(mk(0,0,0,0,1,0,1,2'b01,2'b00,3'b000,0));
      8'h43: q.push_back(mk(0,0,0,0,1,0,1,2'b01,2'b00,3'b010,0));
      8'h44: q.push_back(mk(0,0,0,0,1,0,1,2'b01,2'b00,3'b100,0));
      8'h45: q.push_back(mk(0,0,0,0,1,0,1,2'b01,2'b00,3'b101,0));
      8'h46: q.push_back(mk(0,0,0,0,1,0,1,2'b01,2'b00,3'b001,0));
      8'h48: q.push_back(mk(0,0,0,0,1,0,1,2'b01,2'b00,3'b011,0));
      8'h47: q.push_back(mk(0,0,0,0,0,1,1,2'b10,2'b00,3'b001,0));
      8'h49: q.push_back(mk(0,0,0,0,0,1,1,2'b10,2'b00,3'b011,0));
      default: begin
        if (op >= 8'h20 && op <= 8'h28) begin
          idx = int'(op) - 32;
          if (idx == 0) taken = 1;
          else begin
            flag  = ccr[3 - (idx - 1) / 2];
            taken = ((idx - 1) % 2 == 0) ? flag : !flag;
          end
          if (taken) begin
            q.push_back(mar_pc); q.push_back(idle);
            q.push_back(mk(0,0,1,0,0,0,0,2'b00,2'b10,3'b000,0));
          end else begin
            q.push_back(inc);
          end
        end
      end
    endcase
  endfunction

  task automatic check(input string name, input ow_t got, input ow_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Runs one instruction from F0; flags change to ccr_late after DEC has been left
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input logic [3:0] ccr_late,
                           output int incs, output int wrs);
    ow_t q[$];
    model(op, ccr, q);
    IR_out = op;
    CCR_Result = ccr;
    incs = 0;
    wrs = 0;
    for (int k = 0; k < q.size(); k++) begin
      check($sformatf("op%h_cyc%0d", op, k + 1), dut_w, q[k]);
      incs += int'(PC_Inc);
      wrs  += int'(write);
      if (k == 5) CCR_Result = ccr_late;
      @(posedge Clk); #1;
    end
    check($sformatf("op%h_back_to_f0", op), dut_w, mk(0,1,0,0,0,0,0,2'b00,2'b01,3'b000,0));
  endtask

  typedef struct {
    logic [7:0] op;
    logic [3:0] ccr;
    logic [3:0] ccr_late;
    int         exp_incs;
    int         exp_wrs;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] defined_ops[23];

  initial begin
    int incs, wrs;
    logic [7:0] op;
    ow_t q[$];

    vecs[0]  = '{8'h86, 4'b0000, 4'b0000, 2, 0};
    vecs[1]  = '{8'h43, 4'b0000, 4'b0000, 1, 0};
    vecs[2]  = '{8'h96, 4'b0000, 4'b0000, 2, 1};
    vecs[3]  = '{8'h23, 4'b0100, 4'b0100, 1, 0};
    vecs[4]  = '{8'h23, 4'b0000, 4'b0000, 2, 0};
    vecs[5]  = '{8'h21, 4'b1000, 4'b0000, 1, 0};
    vecs[6]  = '{8'hFF, 4'b1111, 4'b1111, 1, 0};
    vecs[7]  = '{8'h89, 4'b0000, 4'b0000, 2, 0};
    vecs[8]  = '{8'h97, 4'b0000, 4'b0000, 2, 1};
    vecs[9]  = '{8'h47, 4'b0000, 4'b0000, 1, 0};
    vecs[10] = '{8'h20, 4'b0000, 4'b1111, 1, 0};
    vecs[11] = '{8'h28, 4'b0001, 4'b0000, 2, 0};

    defined_ops = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h44, 8'h45,
                    8'h46, 8'h47, 8'h48, 8'h49, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                    8'h26, 8'h27, 8'h28};

    Reset = 1'b0;
    IR_out = 8'h00;
    CCR_Result = 4'b0000;
    @(posedge Clk); @(posedge Clk); #2;
    check("reset_outputs_zero", dut_w, '0);
    #5 Reset = 1'b1;
    #1;

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].op, vecs[i].ccr, vecs[i].ccr_late, incs, wrs);
      check_int($sformatf("vec%0d_pc_inc_count", i), incs, vecs[i].exp_incs);
      check_int($sformatf("vec%0d_write_count", i), wrs, vecs[i].exp_wrs);
    end

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = defined_ops[$urandom_range(0, 22)];
      run_instr(op, 4'($urandom), 4'($urandom), incs, wrs);
    end

    // Reset pulled during the store cycle of STA_DIR
    model(8'h96, 4'b0000, q);
    IR_out = 8'h96;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("sta_rst_cyc%0d", k + 1), dut_w, q[k]);
      @(posedge Clk); #1;
    end
    check("sta_rst_s3_write", dut_w, q[7]);
    #2 Reset = 1'b0;
    #1 check("sta_rst_outputs_drop", dut_w, '0);
    #2 Reset = 1'b1;
    #1;
    run_instr(8'h86, 4'b0000, 4'b0000, incs, wrs);
    check_int("post_reset_lda_incs", incs, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
